// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg
// Shared definitions for the memory access sequencer: FSM state encodings,
// the transaction op bit, the registered control-output bundle and its
// per-state decode, the MDRout bus-select bit index and the default timeout.
package mem_access_ctrl_pkg;

  localparam int DEFAULT_TIMEOUT = 15;
  // Position of the MDR-out bit in the datapath bus-select word.
  localparam int MDROUT_SEL_BIT  = 21;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_LOAD_MAR   = 4'd1,
    ST_RD_WAIT    = 4'd2,
    ST_RD_CAPTURE = 4'd3,
    ST_RD_DRIVE   = 4'd4,
    ST_WR_LOAD    = 4'd5,
    ST_WR_WAIT    = 4'd6,
    ST_WR_DONE    = 4'd7,
    ST_ERR        = 4'd8
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  typedef struct packed {
    logic mar_enable;
    logic mdr_enable;
    logic read_sel;
    logic mem_read;
    logic mem_write;
    logic mdr_out;
    logic busy;
    logic done;
    logic timeout_err;
  } ctrl_t;

  // Moore decode: every control output is a function of the state alone.
  function automatic ctrl_t decode_ctrl(input state_t st);
    ctrl_t c;
    c      = '0;
    c.busy = (st != ST_IDLE);
    unique case (st)
      ST_LOAD_MAR:   c.mar_enable = 1'b1;
      ST_RD_WAIT:    c.mem_read   = 1'b1;
      ST_RD_CAPTURE: begin
        c.mdr_enable = 1'b1;
        c.read_sel   = 1'b1;
      end
      ST_RD_DRIVE: begin
        c.mdr_out = 1'b1;
        c.done    = 1'b1;
      end
      ST_WR_LOAD:    c.mdr_enable = 1'b1;
      ST_WR_WAIT:    c.mem_write  = 1'b1;
      ST_WR_DONE:    c.done       = 1'b1;
      ST_ERR: begin
        c.done        = 1'b1;
        c.timeout_err = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_wait_timer.sv
// mem_access_ctrl_wait_timer
// Wait-cycle counter for the memory handshake. Up-counter that is zeroed by
// clear or load and advances while enable is high. expired flags the last
// permitted wait cycle (count == TIMEOUT-1).
// Ports:
//   clock   - rising-edge clock
//   clear   - synchronous active-high reset
//   load    - zero the count (entry into a wait state)
//   enable  - count this cycle
//   expired - count has reached TIMEOUT-1
module mem_access_ctrl_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clock,
  input  logic clear,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (clear || load) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Sequences one memory transaction at a time through the MAR/MDR path:
// loads MAR, strobes the RAM, waits on mem_ready with a bounded timeout,
// loads the MDR (from Mdatain on reads, from the bus on writes) and drives
// the MDR onto the bus at the end of a read.
//
// state       | meaning
// ------------+---------------------------------------------
// IDLE        | waiting for req_read / req_write
// LOAD_MAR    | MAR loads the address from the bus
// RD_WAIT     | RAM read strobe, waiting for mem_ready
// RD_CAPTURE  | MDR loads from Mdatain
// RD_DRIVE    | MDR drives the bus, done pulse
// WR_LOAD     | MDR loads write data from the bus
// WR_WAIT     | RAM write strobe, waiting for mem_ready
// WR_DONE     | done pulse
// ERR         | mem_ready never came: done + timeout_err
//
// Ports:
//   clock, clear           - clock and synchronous active-high reset
//   req_read, req_write    - single-cycle requests, sampled only in IDLE
//   mem_ready              - RAM completion, honoured only in wait states
//   MAR_enable, MDR_enable - register load enables
//   Read                   - MDR mux select (1 = Mdatain, 0 = bus)
//   mem_read, mem_write    - RAM strobes
//   MDRout                 - MDR bus-select bit
//   busy, done, timeout_err- status
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clock,
  input  logic clear,
  input  logic req_read,
  input  logic req_write,
  input  logic mem_ready,
  output logic MAR_enable,
  output logic MDR_enable,
  output logic Read,
  output logic mem_read,
  output logic mem_write,
  output logic MDRout,
  output logic busy,
  output logic done,
  output logic timeout_err
);

  state_t state;
  state_t state_nxt;
  op_t    op;
  ctrl_t  ctrl;
  logic   in_wait;
  logic   expired;

  assign in_wait = (state == ST_RD_WAIT) || (state == ST_WR_WAIT);

  mem_access_ctrl_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clock  (clock),
    .clear  (clear),
    .load   ((state == ST_LOAD_MAR) || (state == ST_WR_LOAD)),
    .enable (in_wait && !mem_ready),
    .expired(expired)
  );

  // mem_ready takes priority over the timeout in the same cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (req_read || req_write) state_nxt = ST_LOAD_MAR;
      end
      ST_LOAD_MAR:   state_nxt = (op == OP_READ) ? ST_RD_WAIT : ST_WR_LOAD;
      ST_RD_WAIT: begin
        if (mem_ready)    state_nxt = ST_RD_CAPTURE;
        else if (expired) state_nxt = ST_ERR;
      end
      ST_RD_CAPTURE: state_nxt = ST_RD_DRIVE;
      ST_RD_DRIVE:   state_nxt = ST_IDLE;
      ST_WR_LOAD:    state_nxt = ST_WR_WAIT;
      ST_WR_WAIT: begin
        if (mem_ready)    state_nxt = ST_WR_DONE;
        else if (expired) state_nxt = ST_ERR;
      end
      ST_WR_DONE:    state_nxt = ST_IDLE;
      ST_ERR:        state_nxt = ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered alongside the state so they always match the
  // state register, with no decode glitches on the strobes.
  always_ff @(posedge clock) begin
    if (clear) begin
      state <= ST_IDLE;
      op    <= OP_READ;
      ctrl  <= '0;
    end else begin
      state <= state_nxt;
      ctrl  <= decode_ctrl(state_nxt);
      if (state == ST_IDLE) begin
        // Read wins when both requests arrive together.
        if (req_read)       op <= OP_READ;
        else if (req_write) op <= OP_WRITE;
      end
    end
  end

  assign MAR_enable  = ctrl.mar_enable;
  assign MDR_enable  = ctrl.mdr_enable;
  assign Read        = ctrl.read_sel;
  assign mem_read    = ctrl.mem_read;
  assign mem_write   = ctrl.mem_write;
  assign MDRout      = ctrl.mdr_out;
  assign busy        = ctrl.busy;
  assign done        = ctrl.done;
  assign timeout_err = ctrl.timeout_err;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl with a small MAR/MDR datapath model.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  // {MAR_enable, MDR_enable, Read, mem_read, mem_write, MDRout, busy, done, timeout_err}
  localparam logic [8:0] V_IDLE = 9'b000000000;
  localparam logic [8:0] V_LMAR = 9'b100000100;
  localparam logic [8:0] V_RDW  = 9'b000100100;
  localparam logic [8:0] V_RDC  = 9'b011000100;
  localparam logic [8:0] V_RDD  = 9'b000001110;
  localparam logic [8:0] V_WRL  = 9'b010000100;
  localparam logic [8:0] V_WRW  = 9'b000010100;
  localparam logic [8:0] V_WRD  = 9'b000000110;
  localparam logic [8:0] V_ERR  = 9'b000000111;

  logic clock = 1'b0;
  logic clear, req_read, req_write, mem_ready;
  logic MAR_enable, MDR_enable, Read, mem_read, mem_write, MDRout, busy, done, timeout_err;

  logic [31:0] mdatain = 32'h0;
  logic [31:0] bus_drv = 32'h0;
  logic [31:0] mdr = 32'h0;
  logic [31:0] sel_word;
  logic [31:0] bus;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  mem_access_ctrl #(.TIMEOUT(15)) dut (
    .clock(clock), .clear(clear), .req_read(req_read), .req_write(req_write),
    .mem_ready(mem_ready), .MAR_enable(MAR_enable), .MDR_enable(MDR_enable),
    .Read(Read), .mem_read(mem_read), .mem_write(mem_write), .MDRout(MDRout),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  // Datapath slice: MDR with its input mux, and the bus driven by the MDR
  // when its select bit is set.
  assign sel_word = {31'b0, MDRout} << MDROUT_SEL_BIT;
  assign bus      = sel_word[MDROUT_SEL_BIT] ? mdr : bus_drv;
  always @(posedge clock) if (MDR_enable) mdr <= Read ? mdatain : bus;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic chk_ctrl(input string tag, input logic [8:0] exp);
    chk(tag, {23'b0, MAR_enable, MDR_enable, Read, mem_read, mem_write,
              MDRout, busy, done, timeout_err}, {23'b0, exp});
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b1; req_read = 1'b0; req_write = 1'b0; mem_ready = 1'b0;

    // reset with random requests
    for (int i = 0; i < 2; i++) begin
      req_read  = 1'($urandom_range(0, 1));
      req_write = 1'($urandom_range(0, 1));
      mem_ready = 1'($urandom_range(0, 1));
      step();
      chk_ctrl("reset", V_IDLE);
    end
    clear = 1'b0; req_read = 1'b0; req_write = 1'b0; mem_ready = 1'b0;
    step();
    chk_ctrl("idle", V_IDLE);

    // read, zero wait
    mdatain = 32'hDEADBEEF;
    req_read = 1'b1;
    step(); req_read = 1'b0;
    chk_ctrl("rd0_lmar", V_LMAR);
    step();
    chk_ctrl("rd0_wait", V_RDW);
    mem_ready = 1'b1;
    step(); mem_ready = 1'b0;
    chk_ctrl("rd0_capt", V_RDC);
    step();
    chk_ctrl("rd0_drive", V_RDD);
    chk("rd0_bus", bus, 32'hDEADBEEF);
    step();
    chk_ctrl("rd0_idle", V_IDLE);

    // write, 3 extra wait cycles; done at N+7
    bus_drv = 32'h11111111;
    req_write = 1'b1;
    step(); req_write = 1'b0;
    chk_ctrl("wr_lmar", V_LMAR);
    step();
    chk_ctrl("wr_load", V_WRL);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk_ctrl("wr_wait", V_WRW);
      if (i == 1) chk("wr_mdr", mdr, 32'h11111111);
    end
    mem_ready = 1'b1;
    step(); mem_ready = 1'b0;
    chk_ctrl("wr_done", V_WRD);
    step();
    chk_ctrl("wr_idle", V_IDLE);
    bus_drv = 32'h0;

    // timeout: no mem_ready
    req_read = 1'b1;
    step(); req_read = 1'b0;
    chk_ctrl("to_lmar", V_LMAR);
    for (int i = 0; i < 15; i++) begin
      step();
      chk_ctrl("to_wait", V_RDW);
    end
    step();
    chk_ctrl("to_err", V_ERR);
    step();
    chk_ctrl("to_idle", V_IDLE);

    // mem_ready on the 15th wait cycle beats the timeout
    req_read = 1'b1;
    step(); req_read = 1'b0;
    chk_ctrl("rd15_lmar", V_LMAR);
    for (int i = 1; i <= 15; i++) begin
      step();
      chk_ctrl("rd15_wait", V_RDW);
    end
    mem_ready = 1'b1;
    step(); mem_ready = 1'b0;
    chk_ctrl("rd15_capt", V_RDC);
    step();
    chk_ctrl("rd15_drive", V_RDD);
    step();
    chk_ctrl("rd15_idle", V_IDLE);

    // simultaneous requests, then write held during busy
    req_read = 1'b1; req_write = 1'b1;
    step(); req_read = 1'b0;
    chk_ctrl("both_lmar", V_LMAR);
    step();
    chk_ctrl("both_wait", V_RDW);
    mem_ready = 1'b1;
    step(); mem_ready = 1'b0;
    chk_ctrl("both_capt", V_RDC);
    step();
    chk_ctrl("both_drive", V_RDD);
    req_write = 1'b0;
    step();
    chk_ctrl("both_idle", V_IDLE);
    step();
    chk_ctrl("both_idle2", V_IDLE);

    // clear during RD_WAIT: no done, no MDR load
    mdatain = 32'hCAFEF00D;
    req_read = 1'b1;
    step(); req_read = 1'b0;
    chk_ctrl("clr_lmar", V_LMAR);
    step();
    chk_ctrl("clr_wait", V_RDW);
    clear = 1'b1; mem_ready = 1'b1;
    step(); clear = 1'b0; mem_ready = 1'b0;
    chk_ctrl("clr_idle", V_IDLE);
    step();
    chk_ctrl("clr_idle2", V_IDLE);
    chk("clr_mdr", mdr, 32'hDEADBEEF);

    // following read completes; request held after done is accepted
    req_read = 1'b1;
    step(); req_read = 1'b0;
    chk_ctrl("post_lmar", V_LMAR);
    step();
    chk_ctrl("post_wait", V_RDW);
    mem_ready = 1'b1;
    step(); mem_ready = 1'b0;
    chk_ctrl("post_capt", V_RDC);
    step();
    chk_ctrl("post_drive", V_RDD);
    chk("post_bus", bus, 32'hCAFEF00D);
    req_read = 1'b1;
    step();
    chk_ctrl("b2b_idle", V_IDLE);
    step(); req_read = 1'b0;
    chk_ctrl("b2b_lmar", V_LMAR);
    step();
    chk_ctrl("b2b_wait", V_RDW);
    mem_ready = 1'b1;
    step(); mem_ready = 1'b0;
    chk_ctrl("b2b_capt", V_RDC);
    step();
    chk_ctrl("b2b_drive", V_RDD);
    step();
    chk_ctrl("b2b_idle2", V_IDLE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
